gat_bram_pack_loader: RTL and testbench
=======================================

// Module: gat_bram_pack_loader
// PURPOSE
//  Parametrised host-to-BRAM load adapter for the GAT accelerator. Takes 32-bit
//  byte-addressed writes from an AXI BRAM controller port. Packs BEATS consecutive
//  words into one DATA_WIDTH-bit entry, so entries wider than 32 b (WH rows, node_info)
//  load correctly. Tracks load completion and supports beat-wise debug readback.
//  One instance sits in front of each feature/weight/node-info BRAM.
// PARAMETERS
//  DATA_WIDTH   44     width of one packed BRAM entry (1..256)
//  DEPTH        13264  number of entries
//  BUS_WIDTH    32     host data width; fixed
//  BEATS        ceil(DATA_WIDTH/32)  words per entry (local)
//  BEAT_W       max(1,$clog2(BEATS)); per-entry word stride = 2**BEAT_W (local)
//  ADDR_W       $clog2(DEPTH)  entry address width (local)
//  RD_LATENCY   2      core BRAM read latency in cycles (1..4)
// PORTS
//  clk           in   1                   clock
//  rst           in   1                   asynchronous reset, active-high
//  load_start    in   1                   pulse: clear counters/status, enter LOAD
//  load_done_in  in   1                   pulse from register bank: host finished writing
//  bus_en        in   1                   host access strobe
//  bus_we        in   1                   1 = write, 0 = read (qualified by bus_en)
//  bus_addr      in   ADDR_W+BEAT_W+2     byte address; bits [1:0] ignored
//  bus_din       in   32                  host write data
//  bus_dout      out  32                  readback beat, zero-extended
//  bus_rvalid    out  1                   bus_dout valid pulse
//  mem_we        out  1                   packed-entry write strobe
//  mem_waddr     out  ADDR_W              packed-entry write address
//  mem_wdata     out  DATA_WIDTH          packed-entry write data
//  mem_raddr     out  ADDR_W              readback address to BRAM
//  mem_rdata     in   DATA_WIDTH          BRAM read data, RD_LATENCY after mem_raddr
//  load_done     out  1                   level: all accepted entries committed
//  entry_cnt     out  ADDR_W+1            entries committed since load_start
//  err_order     out  1                   sticky: out-of-order/over-range write seen
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; beat buffer cleared.
//  Decode: word = bus_addr[ADDR_W+BEAT_W+1:2]; beat = word[BEAT_W-1:0]; entry = word>>BEAT_W
//   (BEATS==1: beat=0, entry=word).
//  FSM IDLE -load_start-> LOAD -load_done_in-> FLUSH -(no pending commit)-> DONE -load_start-> LOAD.
//  load_start has priority over every other event in every state. It clears entry_cnt,
//   err_order, load_done and the partial buffer in the same cycle.
//  Writes are accepted only in LOAD. Writes in IDLE/FLUSH/DONE are ignored; they set err_order in FLUSH/DONE.
//  Packing: beats must arrive 0,1,..,BEATS-1 for one entry. A beat k<BEATS-1 is stored in
//   the buffer. The last beat commits next cycle: mem_we=1 for exactly 1 cycle, with
//   mem_waddr=entry and mem_wdata={last[..],..,beat0} truncated to DATA_WIDTH.
//   entry_cnt then increments.
//  Order error: beat != expected, entry change mid-entry, beat>=BEATS, or entry>=DEPTH.
//   Sets err_order, drops the partial entry, writes nothing. A beat-0 write that causes the error
//   restarts a new entry.
//  Back-to-back writes every cycle are supported; commit latency is fixed at 1 cycle.
//  FLUSH waits for the in-flight commit, then enters DONE and sets load_done.
//   A leftover partial entry sets err_order and is discarded.
//  entry_cnt saturates at DEPTH.
//  Readback (any state, bus_en & !bus_we): mem_raddr=entry next cycle.
//   bus_dout = beat slice of mem_rdata, with bus_rvalid=1 pulse, RD_LATENCY+1 cycles after request.
//   Requests pipeline one per cycle; beat>=BEATS returns 0.
//   A read and a commit to the same entry in flight: the read returns old data (no bypass).
//  Reset mid-load: all state is lost and the FSM goes to IDLE; partial entries are never written.
// TESTING
//  DATA_WIDTH=44, BEATS=2: write 0x000=0x89ABCDEF, 0x004=0x123 -> next cycle mem_we=1,
//   waddr=0, wdata=44'h123_89ABCDEF, entry_cnt=1.
//  Stream 8 entries back-to-back (16 writes, 16 cycles), then load_done_in -> 8 mem_we pulses,
//   load_done=1 one cycle after last commit, err_order=0.
//  Beat1 before beat0 of entry 5 (0x02C then 0x028) -> err_order=1, no write for the beat1;
//   the entry then completes normally after a correct beat1.
//  load_done_in with only beat0 of entry 3 written -> DONE, err_order=1, entry_cnt unchanged.
//  RD_LATENCY=2: read 0x004 after entry 0 commit -> bus_rvalid at +3 cycles, bus_dout=0x00000123.
//  Assert rst mid-entry, then load_start -> outputs 0; next full entry writes correctly, entry_cnt=1.

Source files
------------

// File: rtl/gat_bram_pack_loader.sv
// gat_bram_pack_loader
// Host-to-BRAM load adapter: packs consecutive 32-bit host beats into one wide
// BRAM entry, tracks load completion and serves beat-wise readback.
module gat_bram_pack_loader #(
  parameter int DATA_WIDTH = 44,
  parameter int DEPTH      = 13264,
  parameter int BUS_WIDTH  = 32,
  parameter int RD_LATENCY = 2,
  localparam int BEATS  = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BA_W   = ADDR_W + BEAT_W + 2,
  localparam int BUF_W  = (BEATS > 1) ? (BEATS - 1) * BUS_WIDTH : BUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_done_in,
  input  logic                  bus_en,
  input  logic                  bus_we,
  input  logic [BA_W-1:0]       bus_addr,
  input  logic [BUS_WIDTH-1:0]  bus_din,
  output logic [BUS_WIDTH-1:0]  bus_dout,
  output logic                  bus_rvalid,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  load_done,
  output logic [ADDR_W:0]       entry_cnt,
  output logic                  err_order
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BEAT_W:0]   BEATS_L   = (BEAT_W + 1)'(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  logic [1:0]            r_state;
  logic                  r_load_done;
  logic [ADDR_W:0]       r_entry_cnt;
  logic                  r_err_order;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_waddr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [ADDR_W-1:0]     r_mem_raddr;
  logic                  r_partial;
  logic [BEAT_W-1:0]     r_exp_beat;
  logic [ADDR_W-1:0]     r_cur_entry;
  logic [BUF_W-1:0]      r_buf;
  logic [RD_LATENCY:0]   r_rv_pipe;
  logic [RD_LATENCY:0]   r_roob_pipe;
  logic [BEAT_W-1:0]     r_rbeat_pipe [0:RD_LATENCY];

  logic [ADDR_W+BEAT_W-1:0]    w_word;
  logic [BEAT_W-1:0]           w_beat;
  logic [ADDR_W:0]             w_entry;
  logic [DATA_WIDTH-1:0]       w_packed;
  logic                        w_beat_ok;
  logic                        w_entry_ok;
  logic                        w_in_order;
  logic                        w_last;
  logic                        w_wr;
  logic                        w_rd;
  logic                        w_wr_load;
  logic                        w_accept_last;
  logic                        w_accept_mid;
  logic                        w_order_err;
  logic                        w_restart;
  logic                        w_wr_err;
  logic                        w_flush_drop;
  logic [BEATS*BUS_WIDTH-1:0]  w_rdata_pad;
  logic [BUS_WIDTH-1:0]        w_slice;
  logic                        w_unused;

  // Byte offset inside a word carries no information for a word-wide bus.
  assign w_unused = ^bus_addr[1:0];
  assign w_word   = bus_addr[BA_W-1:2];

  generate
    if (BEATS == 1) begin : g_single
      assign w_beat   = {BEAT_W{1'b0}};
      assign w_entry  = w_word;
      assign w_packed = DATA_WIDTH'(bus_din);
    end else begin : g_multi
      assign w_beat   = w_word[BEAT_W-1:0];
      assign w_entry  = {1'b0, w_word[ADDR_W+BEAT_W-1:BEAT_W]};
      // Last beat is the most significant word; excess high bits are dropped.
      assign w_packed = DATA_WIDTH'({bus_din, r_buf});
    end
  endgenerate

  assign w_wr       = bus_en & bus_we;
  assign w_rd       = bus_en & ~bus_we;
  assign w_wr_load  = w_wr & (r_state == S_LOAD);
  assign w_beat_ok  = ({1'b0, w_beat} < BEATS_L);
  assign w_entry_ok = (w_entry < DEPTH_L);
  assign w_last     = (w_beat == LAST_BEAT);
  // A continuing beat must target the entry already being assembled.
  assign w_in_order = w_beat_ok & w_entry_ok & (w_beat == r_exp_beat) &
                      (~r_partial | (w_entry[ADDR_W-1:0] == r_cur_entry));
  assign w_accept_last = w_wr_load & w_in_order & w_last;
  assign w_accept_mid  = w_wr_load & w_in_order & ~w_last;
  assign w_order_err   = w_wr_load & ~w_in_order;
  // An erroneous beat 0 is still a valid start of a fresh entry.
  assign w_restart     = w_order_err & (w_beat == {BEAT_W{1'b0}}) & w_entry_ok & ~w_last;
  assign w_wr_err      = w_order_err | (w_wr & ((r_state == S_FLUSH) | (r_state == S_DONE)));
  assign w_flush_drop  = (r_state == S_FLUSH) & r_partial;

  // Load FSM, completion flag, saturating entry counter and sticky order error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_load_done <= 1'b0;
      r_entry_cnt <= {(ADDR_W+1){1'b0}};
      r_err_order <= 1'b0;
    end else if (load_start) begin
      r_state     <= S_LOAD;
      r_load_done <= 1'b0;
      r_entry_cnt <= {(ADDR_W+1){1'b0}};
      r_err_order <= 1'b0;
    end else begin
      if (w_accept_last && (r_entry_cnt != DEPTH_L)) begin
        r_entry_cnt <= r_entry_cnt + CNT_ONE;
      end else begin
        r_entry_cnt <= r_entry_cnt;
      end
      if (w_wr_err || w_flush_drop) begin
        r_err_order <= 1'b1;
      end else begin
        r_err_order <= r_err_order;
      end
      case (r_state)
        S_IDLE:  r_state <= S_IDLE;
        S_LOAD:  r_state <= load_done_in ? S_FLUSH : S_LOAD;
        // The commit issued from LOAD is already on mem_we during this cycle.
        S_FLUSH: begin
          r_state     <= S_DONE;
          r_load_done <= 1'b1;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Partial-entry assembly: expected beat, current entry and beat buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_partial   <= 1'b0;
      r_exp_beat  <= {BEAT_W{1'b0}};
      r_cur_entry <= {ADDR_W{1'b0}};
      r_buf       <= {BUF_W{1'b0}};
    end else if (load_start || w_flush_drop) begin
      r_partial   <= 1'b0;
      r_exp_beat  <= {BEAT_W{1'b0}};
      r_cur_entry <= {ADDR_W{1'b0}};
      r_buf       <= {BUF_W{1'b0}};
    end else if (w_accept_mid || w_restart) begin
      r_partial   <= 1'b1;
      r_exp_beat  <= w_beat + BEAT_ONE;
      r_cur_entry <= w_entry[ADDR_W-1:0];
      for (int k = 0; k < BEATS - 1; k++) begin
        if (w_beat == BEAT_W'(k)) begin
          r_buf[k*BUS_WIDTH +: BUS_WIDTH] <= bus_din;
        end
      end
    end else if (w_accept_last || w_order_err) begin
      r_partial  <= 1'b0;
      r_exp_beat <= {BEAT_W{1'b0}};
    end else begin
      r_partial <= r_partial;
    end
  end

  // Single-cycle commit of a completed entry to the BRAM write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_waddr <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_WIDTH{1'b0}};
    end else if (load_start) begin
      r_mem_we <= 1'b0;
    end else begin
      r_mem_we <= w_accept_last;
      if (w_accept_last) begin
        r_mem_waddr <= w_entry[ADDR_W-1:0];
        r_mem_wdata <= w_packed;
      end else begin
        r_mem_waddr <= r_mem_waddr;
      end
    end
  end

  // Readback address and request tracking aligned to the BRAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_raddr <= {ADDR_W{1'b0}};
      r_rv_pipe   <= {(RD_LATENCY+1){1'b0}};
      r_roob_pipe <= {(RD_LATENCY+1){1'b0}};
      for (int i = 0; i <= RD_LATENCY; i++) begin
        r_rbeat_pipe[i] <= {BEAT_W{1'b0}};
      end
    end else begin
      if (w_rd) begin
        r_mem_raddr <= w_entry[ADDR_W-1:0];
      end else begin
        r_mem_raddr <= r_mem_raddr;
      end
      r_rv_pipe       <= {r_rv_pipe[RD_LATENCY-1:0], w_rd};
      r_roob_pipe     <= {r_roob_pipe[RD_LATENCY-1:0], ~w_beat_ok};
      r_rbeat_pipe[0] <= w_beat;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        r_rbeat_pipe[i] <= r_rbeat_pipe[i-1];
      end
    end
  end

  assign w_rdata_pad = (BEATS*BUS_WIDTH)'(mem_rdata);

  // Beat selection from the returning BRAM word
  always_comb begin
    w_slice = {BUS_WIDTH{1'b0}};
    for (int k = 0; k < BEATS; k++) begin
      if (r_rbeat_pipe[RD_LATENCY] == BEAT_W'(k)) begin
        w_slice = w_rdata_pad[k*BUS_WIDTH +: BUS_WIDTH];
      end else begin
        w_slice = w_slice;
      end
    end
  end

  // Data arrives from the BRAM in the valid cycle itself, so the mux is not re-registered.
  assign bus_dout   = (r_rv_pipe[RD_LATENCY] && !r_roob_pipe[RD_LATENCY]) ? w_slice : {BUS_WIDTH{1'b0}};
  assign bus_rvalid = r_rv_pipe[RD_LATENCY];
  assign mem_we     = r_mem_we;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_raddr  = r_mem_raddr;
  assign load_done  = r_load_done;
  assign entry_cnt  = r_entry_cnt;
  assign err_order  = r_err_order;

endmodule

// File: tb/tb_gat_bram_pack_loader.sv
// Testbench for gat_bram_pack_loader (DATA_WIDTH=44, two beats per entry).
`timescale 1ns/1ps
module tb_gat_bram_pack_loader;
  localparam int DW = 44, DEPTH = 13264, RDL = 2, AW = 14, BAW = 17;

  logic clk = 1'b0;
  logic rst, load_start, load_done_in, bus_en, bus_we;
  logic [BAW-1:0] bus_addr;
  logic [31:0] bus_din, bus_dout;
  logic bus_rvalid, mem_we, load_done, err_order;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW:0] entry_cnt;

  always #5 clk = ~clk;

  gat_bram_pack_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BUS_WIDTH(32), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_done_in(load_done_in),
    .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_dout(bus_dout), .bus_rvalid(bus_rvalid), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .load_done(load_done), .entry_cnt(entry_cnt), .err_order(err_order));

  // BRAM model with two-cycle read latency
  logic [DW-1:0] bram [0:DEPTH-1];
  logic [DW-1:0] rd_q1, rd_q2;
  always @(posedge clk) begin
    if (mem_we) bram[mem_waddr] <= mem_wdata;
    rd_q1 <= bram[mem_raddr];
    rd_q2 <= rd_q1;
  end
  assign mem_rdata = rd_q2;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t wq[$];
  logic [31:0] rq[$];
  logic [DW-1:0] shadow [int];
  int errors = 0, checks = 0, n_commits = 0;

  typedef struct {
    logic [BAW-1:0] addr; logic [31:0] din;
    logic commit; int entry; logic [31:0] lo;
    logic exp_err; int exp_cnt;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, scoreboard popped on valid strobes
  task automatic tick();
    wr_t e;
    @(posedge clk); #1;
    if (mem_we) begin
      n_commits++;
      if (wq.size() == 0) chk("unexpected_mem_we", 64'd1, 64'd0);
      else begin
        e = wq.pop_front();
        chk("mem_waddr", 64'(mem_waddr), 64'(e.a));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
      end
    end
    if (bus_rvalid) begin
      if (rq.size() == 0) chk("unexpected_rvalid", 64'd1, 64'd0);
      else chk("bus_dout", 64'(bus_dout), 64'(rq.pop_front()));
    end
  endtask

  task automatic expect_commit(input int e, input logic [31:0] b0, input logic [31:0] b1);
    logic [63:0] full;
    wr_t x;
    full = {b1, b0};
    x.a = AW'(e);
    x.d = full[DW-1:0];
    wq.push_back(x);
    shadow[e] = full[DW-1:0];
  endtask

  task automatic wr(input logic [BAW-1:0] a, input logic [31:0] d, input logic done_in);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_din = d; load_done_in = done_in;
    tick();
    bus_en = 1'b0; bus_we = 1'b0; load_done_in = 1'b0;
  endtask

  task automatic rd(input logic [BAW-1:0] a);
    int e;
    logic [DW-1:0] w;
    e = int'(a >> 3);
    w = shadow.exists(e) ? shadow[e] : {DW{1'b0}};
    rq.push_back(a[2] ? {20'd0, w[43:32]} : w[31:0]);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick();
    bus_en = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b0, b1;
    vt[0] = '{17'h00000, 32'h89ABCDEF, 1'b0, 0, 32'h0,        1'b0, 0};
    vt[1] = '{17'h00004, 32'h00000123, 1'b1, 0, 32'h89ABCDEF, 1'b0, 1};
    vt[2] = '{17'h0002C, 32'h55555555, 1'b0, 0, 32'h0,        1'b1, 1};
    vt[3] = '{17'h00028, 32'h0A0A0A0A, 1'b0, 0, 32'h0,        1'b1, 1};
    vt[4] = '{17'h0002C, 32'h00000ABC, 1'b1, 5, 32'h0A0A0A0A, 1'b1, 2};
    vt[5] = '{17'h00030, 32'h11111111, 1'b0, 0, 32'h0,        1'b1, 2};
    vt[6] = '{17'h00038, 32'h22222222, 1'b0, 0, 32'h0,        1'b1, 2};
    vt[7] = '{17'h0003C, 32'hFFFFF456, 1'b1, 7, 32'h22222222, 1'b1, 3};
    vt[8] = '{17'h19E80, 32'h33333333, 1'b0, 0, 32'h0,        1'b1, 3};
    vt[9] = '{17'h19E84, 32'h44444444, 1'b0, 0, 32'h0,        1'b1, 3};

    rst = 1'b1; load_start = 1'b0; load_done_in = 1'b0;
    bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_din = '0;
    tick(); tick();
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_entry_cnt", 64'(entry_cnt), 64'd0);
    chk("rst_err_order", 64'(err_order), 64'd0);
    chk("rst_rvalid", 64'(bus_rvalid), 64'd0);
    rst = 1'b0;
    tick();

    // Table: packing, order errors, restart on beat 0, out-of-range entry
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (vt[i].commit) expect_commit(vt[i].entry, vt[i].lo, vt[i].din);
      wr(vt[i].addr, vt[i].din, 1'b0);
      chk($sformatf("vec%0d_mem_we", i), 64'(mem_we), 64'(vt[i].commit));
      chk($sformatf("vec%0d_err", i), 64'(err_order), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d_cnt", i), 64'(entry_cnt), 64'(vt[i].exp_cnt));
    end
    tick();
    chk("table_commits_drained", 64'(wq.size()), 64'd0);

    // Readback latency: entry 0 beat 1 returns 0x123 three cycles after request
    rd(17'h00004);
    chk("rd_lat_c1", 64'(bus_rvalid), 64'd0);
    tick();
    chk("rd_lat_c2", 64'(bus_rvalid), 64'd0);
    tick();
    chk("rd_lat_c3", 64'(bus_rvalid), 64'd1);
    tick();
    chk("rd_pulse_end", 64'(bus_rvalid), 64'd0);

    // Stream 8 entries back-to-back, load_done_in with the last beat
    pulse_start();
    chk("start_cnt_clear", 64'(entry_cnt), 64'd0);
    chk("start_err_clear", 64'(err_order), 64'd0);
    n_commits = 0;
    for (int i = 0; i < 8; i++) begin
      b0 = $urandom; b1 = $urandom;
      expect_commit(i, b0, b1);
      wr(BAW'(i * 8), b0, 1'b0);
      wr(BAW'(i * 8 + 4), b1, (i == 7) ? 1'b1 : 1'b0);
    end
    chk("stream_last_commit", 64'(mem_we), 64'd1);
    chk("stream_done_not_yet", 64'(load_done), 64'd0);
    tick();
    chk("stream_load_done", 64'(load_done), 64'd1);
    chk("stream_commits", 64'(n_commits), 64'd8);
    chk("stream_cnt", 64'(entry_cnt), 64'd8);
    chk("stream_err", 64'(err_order), 64'd0);
    wr(17'h00040, 32'hCAFEF00D, 1'b0);
    chk("done_write_err", 64'(err_order), 64'd1);
    chk("done_write_no_we", 64'(mem_we), 64'd0);

    // Pipelined readback of streamed entries
    rd(17'h00000); rd(17'h00004); rd(17'h00028); rd(17'h0002C); rd(17'h00038); rd(17'h0003C);
    for (int i = 0; i < 4; i++) tick();
    chk("reads_drained", 64'(rq.size()), 64'd0);

    // Flush with a leftover partial entry
    pulse_start();
    chk("start2_done_clear", 64'(load_done), 64'd0);
    wr(17'h00018, 32'h00000077, 1'b0);
    chk("partial_no_err", 64'(err_order), 64'd0);
    load_done_in = 1'b1;
    tick();
    load_done_in = 1'b0;
    tick();
    chk("flush_load_done", 64'(load_done), 64'd1);
    chk("flush_err", 64'(err_order), 64'd1);
    chk("flush_cnt", 64'(entry_cnt), 64'd0);

    // Reset in the middle of a load
    pulse_start();
    expect_commit(0, 32'h01020304, 32'h00000A0B);
    wr(17'h00000, 32'h01020304, 1'b0);
    wr(17'h00004, 32'h00000A0B, 1'b0);
    wr(17'h0000C, 32'h0000000C, 1'b0);
    wr(17'h00010, 32'h0000DEAD, 1'b0);
    chk("pre_rst_cnt", 64'(entry_cnt), 64'd1);
    chk("pre_rst_err", 64'(err_order), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", 64'(entry_cnt), 64'd0);
    chk("mid_rst_err", 64'(err_order), 64'd0);
    chk("mid_rst_done", 64'(load_done), 64'd0);
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    wr(17'h00014, 32'h0000BEEF, 1'b0);
    chk("idle_write_no_we", 64'(mem_we), 64'd0);
    chk("idle_write_no_err", 64'(err_order), 64'd0);
    pulse_start();
    expect_commit(2, 32'h5A5A5A5A, 32'h00000789);
    wr(17'h00010, 32'h5A5A5A5A, 1'b0);
    wr(17'h00014, 32'h00000789, 1'b0);
    chk("post_rst_we", 64'(mem_we), 64'd1);
    chk("post_rst_cnt", 64'(entry_cnt), 64'd1);
    tick(); tick();
    chk("final_wq_empty", 64'(wq.size()), 64'd0);
    chk("final_rq_empty", 64'(rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
